// File: rtl/cachetest_req.sv
// Cache test request driver: issues alternating write/read-back pairs to the cache under test,
// tracks written data in a shadow memory and counts read mismatches and request timeouts.
module cachetest_req #(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned SHADOW_AW = 8,
   parameter int unsigned STRIDE    = 37,
   parameter int unsigned NUM_PAIRS = 512,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gen_valid,
   output logic              gen_ready,
   output logic              cache_valid,
   output logic              cache_wr,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [31:0]       cache_wdata,
   input  logic              cache_ready,
   input  logic [31:0]       cache_rdata,
   output logic              done,
   output logic              err_flag,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] err_addr
);

   localparam int unsigned OP_W  = $clog2(2 * NUM_PAIRS + 1);
   localparam int unsigned K_W   = OP_W - 1;
   localparam int unsigned DEPTH = 1 << SHADOW_AW;

   localparam logic [OP_W-1:0]      OP_LAST  = OP_W'(2 * NUM_PAIRS);
   localparam logic [SHADOW_AW-1:0] STRIDE_W = SHADOW_AW'(STRIDE);
   localparam logic [7:0]           TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [7:0]          tmo_q, tmo_d;
   logic                done_q, done_d;
   logic                err_flag_q, err_flag_d;
   logic [15:0]         err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
   logic [DEPTH-1:0]    sv_q, sv_d;
   logic [31:0]         shadow_q [DEPTH];

   logic [K_W-1:0]       k;
   logic [SHADOW_AW-1:0] k_w;
   logic [SHADOW_AW-1:0] word_idx;
   logic [ADDR_W-1:0]    op_addr;
   logic [31:0]          op_wdata;
   logic                 op_is_wr;
   logic                 shadow_we;
   logic                 err_ev;
   logic                 op_adv;

   // Address and data are pure functions of the op counter, so they stay stable for the whole REQ.
   assign k        = op_q[OP_W-1:1];
   assign k_w      = SHADOW_AW'(k);
   assign word_idx = k_w * STRIDE_W;
   assign op_addr  = ADDR_W'({word_idx, 2'b00});
   assign op_wdata = 32'hA500_0000 ^ {16'h0000, 16'(k)};
   assign op_is_wr = ~op_q[0];

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      tmo_d      = tmo_q;
      done_d     = done_q;
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      sv_d       = sv_q;
      shadow_we  = 1'b0;
      err_ev     = 1'b0;
      op_adv     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (gen_valid && !done_q) begin
               state_d = S_REQ;
               tmo_d   = '0;
            end
         end
         S_REQ: begin
            if (cache_ready) begin
               state_d = S_IDLE;
               op_adv  = 1'b1;
               if (op_is_wr) begin
                  shadow_we      = 1'b1;
                  sv_d[word_idx] = 1'b1;
               end else if (sv_q[word_idx] && (cache_rdata != shadow_q[word_idx])) begin
                  err_ev = 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               // Abandoned op: no shadow update, but the sequence still moves on.
               state_d = S_IDLE;
               op_adv  = 1'b1;
               err_ev  = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (op_adv) begin
         op_d = op_q + 1'b1;
         if (op_d == OP_LAST) begin
            done_d = 1'b1;
         end
      end

      if (err_ev) begin
         err_flag_d = 1'b1;
         if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
         if (!err_flag_q) begin
            err_addr_d = op_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         tmo_q      <= '0;
         done_q     <= 1'b0;
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         sv_q       <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         tmo_q      <= tmo_d;
         done_q     <= done_d;
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         sv_q       <= sv_d;
      end
   end

   always_ff @(posedge clk) begin
      if (shadow_we) begin
         shadow_q[word_idx] <= op_wdata;
      end
   end

   assign cache_valid = (state_q == S_REQ);
   assign gen_ready   = (state_q == S_IDLE) && !done_q;
   assign cache_wr    = cache_valid & op_is_wr;
   assign cache_addr  = cache_valid ? op_addr  : '0;
   assign cache_wdata = cache_valid ? op_wdata : '0;
   assign done        = done_q;
   assign err_flag    = err_flag_q;
   assign err_count   = err_cnt_q;
   assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_cachetest_req.sv
// Randomized bench for cachetest_req: a behavioural cache plus a reference model of the
// expected request sequence, shadow contents and error bookkeeping.
module tb_cachetest_req;

   localparam int STRIDE = 37;
   localparam int NP     = 512;
   localparam int TMO    = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        gen_valid;
   logic        gen_ready;
   logic        cache_valid;
   logic        cache_wr;
   logic [23:0] cache_addr;
   logic [31:0] cache_wdata;
   logic        cache_ready;
   logic [31:0] cache_rdata;
   logic        done;
   logic        err_flag;
   logic [15:0] err_count;
   logic [23:0] err_addr;

   always #5 clk = ~clk;

   cachetest_req #(
      .ADDR_W   (24),
      .SHADOW_AW(8),
      .STRIDE   (STRIDE),
      .NUM_PAIRS(NP),
      .TIMEOUT  (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .gen_valid  (gen_valid),
      .gen_ready  (gen_ready),
      .cache_valid(cache_valid),
      .cache_wr   (cache_wr),
      .cache_addr (cache_addr),
      .cache_wdata(cache_wdata),
      .cache_ready(cache_ready),
      .cache_rdata(cache_rdata),
      .done       (done),
      .err_flag   (err_flag),
      .err_count  (err_count),
      .err_addr   (err_addr)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state
   int          m_op;
   int          m_err;
   bit          m_flag;
   int          m_eaddr;
   bit          m_done;
   logic [31:0] m_sh [int];
   logic [31:0] cmem [int];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int exp_idx(input int op);
      return ((op / 2) * STRIDE) % 256;
   endfunction

   function automatic logic [31:0] exp_wdata(input int op);
      return 32'hA500_0000 ^ (op / 2);
   endfunction

   function automatic void m_clear();
      m_op = 0; m_err = 0; m_flag = 0; m_eaddr = 0; m_done = 0;
      m_sh.delete();
   endfunction

   function automatic void model_err(input int a);
      if (m_err < 65535) m_err++;
      if (!m_flag) begin
         m_flag  = 1;
         m_eaddr = a;
      end
   endfunction

   function automatic void model_complete(input int idx, input bit wr, input logic [31:0] wd,
                                          input logic [31:0] rd);
      if (wr) begin
         cmem[idx] = wd;
         m_sh[idx] = wd;
      end else if (m_sh.exists(idx) && rd != m_sh[idx]) begin
         model_err(idx * 4);
      end
      m_op++;
      if (m_op == 2 * NP) m_done = 1;
   endfunction

   function automatic logic [31:0] cache_read(input int idx);
      return cmem.exists(idx) ? cmem[idx] : 32'hDEAD_BEEF;
   endfunction

   task automatic check_status(input string tag);
      check_eq({tag, "_valid"},    cache_valid, 0);
      check_eq({tag, "_errcnt"},   err_count, m_err);
      check_eq({tag, "_errflag"},  err_flag, m_flag);
      check_eq({tag, "_erraddr"},  err_addr, m_eaddr);
      check_eq({tag, "_done"},     done, m_done);
      check_eq({tag, "_genready"}, gen_ready, !m_done);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; gen_valid = 0; cache_ready = 0;
      @(negedge clk);
      rst = 0;
      m_clear();
   endtask

   task automatic do_op(input int lat, input bit corrupt, input bit hang, input bit poke);
      int          idx;
      bit          wr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          n;
      idx = exp_idx(m_op);
      wr  = (m_op % 2) == 0;
      wd  = exp_wdata(m_op);
      rd  = '0;
      if (poke) begin
         cache_ready = 1; cache_rdata = $urandom;
         @(negedge clk);
         cache_ready = 0;
         check_eq("idle_ready_valid", cache_valid, 0);
         check_eq("idle_ready_errcnt", err_count, m_err);
      end
      check_eq("idle_gen_ready", gen_ready, 1);
      gen_valid = 1;
      @(negedge clk);
      check_eq("req_valid", cache_valid, 1);
      check_eq("req_gen_ready", gen_ready, 0);
      check_eq("req_wr", cache_wr, wr);
      check_eq("req_addr", cache_addr, idx * 4);
      if (wr) check_eq("req_wdata", cache_wdata, wd);
      if (hang) begin
         gen_valid = 0;
         n = 1;
         while (n < TMO + 20) begin
            @(negedge clk);
            if (!cache_valid) break;
            n++;
         end
         check_eq("timeout_cycles", n, TMO);
         model_err(idx * 4);
         m_op++;
         if (m_op == 2 * NP) m_done = 1;
      end else begin
         repeat (lat) begin
            @(negedge clk);
            check_eq("hold_req", {cache_valid, cache_wr, cache_addr}, {1'b1, wr, 24'(idx * 4)});
         end
         gen_valid   = 0;
         cache_ready = 1;
         if (wr) cache_rdata = $urandom;
         else begin
            rd = cache_read(idx);
            if (corrupt) rd ^= 32'h1;
            cache_rdata = rd;
         end
         @(negedge clk);
         cache_ready = 0;
         model_complete(idx, wr, wd, rd);
      end
      check_status("post_op");
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          idx;
      bit          wr;
      logic [31:0] rd;
      rst = 1; gen_valid = 0; cache_ready = 0; cache_rdata = '0;
      m_clear();
      repeat (2) @(negedge clk);
      do_reset();

      // Reset state
      check_eq("rst_gen_ready", gen_ready, 1);
      check_eq("rst_cache_valid", cache_valid, 0);
      check_eq("rst_cache_wr", cache_wr, 0);
      check_eq("rst_cache_addr", cache_addr, 0);
      check_eq("rst_cache_wdata", cache_wdata, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err_flag", err_flag, 0);
      check_eq("rst_err_count", err_count, 0);
      check_eq("rst_err_addr", err_addr, 0);

      // Ideal cache, full run, with stray cache_ready pulses while idle
      for (int i = 0; i < 2 * NP; i++)
         do_op($urandom_range(0, 3), 0, 0, $urandom_range(0, 7) == 0);
      check_eq("run1_done", done, 1);
      check_eq("run1_errcnt", err_count, 0);
      gen_valid = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("done_ignores_gen", cache_valid, 0);
         check_eq("done_gen_ready", gen_ready, 0);
      end
      gen_valid = 0;

      // Corrupted read of k=3, then sparse random corruptions
      do_reset();
      for (int i = 0; i < 2 * NP; i++) begin
         do_op($urandom_range(0, 3),
               (i == 7) || (i > 100 && (i % 2) == 1 && $urandom_range(0, 15) == 0), 0, 0);
         if (i == 7) begin
            check_eq("k3_err_count", err_count, 1);
            check_eq("k3_err_addr", err_addr, 24'h1BC);
         end
      end
      check_eq("run2_done", done, 1);
      check_eq("run2_err_addr", err_addr, 24'h1BC);

      // Timeouts, ready on the last allowed cycle, unchecked read after abandoned write
      do_reset();
      for (int i = 0; i < 5; i++) do_op($urandom_range(0, 3), 0, 0, 0);
      do_op(0, 0, 1, 0);
      check_eq("tmo_err_count", err_count, 1);
      check_eq("tmo_err_addr", err_addr, 24'h128);
      for (int i = 6; i < 10; i++) do_op($urandom_range(0, 3), 0, 0, 0);
      do_op(TMO - 1, 0, 0, 0);
      check_eq("ready_on_tmo_cycle", err_count, 1);
      do_op(1, 0, 0, 0);
      do_op(0, 0, 1, 0);
      do_op(1, 1, 0, 0);
      check_eq("unwritten_read_unchecked", err_count, 2);

      // Back-to-back: gen_valid held, ready in the same cycle as valid
      do_reset();
      gen_valid = 1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         check_eq("b2b_valid", cache_valid, j % 2);
         check_eq("b2b_gen_ready", gen_ready, (j % 2) == 0);
         if (cache_valid) begin
            idx = exp_idx(m_op);
            wr  = (m_op % 2) == 0;
            check_eq("b2b_addr", cache_addr, idx * 4);
            rd = wr ? 32'h0 : cache_read(idx);
            cache_rdata = rd;
            cache_ready = 1;
            model_complete(idx, wr, exp_wdata(m_op), rd);
         end else begin
            cache_ready = 0;
         end
      end
      gen_valid = 0;
      @(negedge clk);
      check_status("b2b_end");
      do_op(1, 0, 0, 0);

      // Reset in the middle of op 7
      do_reset();
      for (int i = 0; i < 7; i++) do_op($urandom_range(0, 3), 0, 0, 0);
      gen_valid = 1;
      @(negedge clk);
      check_eq("op7_valid", cache_valid, 1);
      gen_valid = 0;
      rst = 1;
      @(negedge clk);
      check_eq("midreset_valid", cache_valid, 0);
      check_eq("midreset_gen_ready", gen_ready, 1);
      rst = 0;
      m_clear();
      gen_valid = 1;
      @(negedge clk);
      check_eq("restart_wr", cache_wr, 1);
      check_eq("restart_addr", cache_addr, 0);
      check_eq("restart_wdata", cache_wdata, 32'hA500_0000);
      gen_valid = 0; cache_ready = 1;
      @(negedge clk);
      cache_ready = 0;
      model_complete(0, 1, 32'hA500_0000, 0);
      check_status("restart");
      do_op(2, 0, 0, 0);

      // Saturation of err_count
      do_reset();
      for (int i = 0; i < 6; i++) do_op($urandom_range(0, 3), 0, 0, 0);
      @(negedge clk);
      force dut.err_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.err_cnt_q;
      m_err = 16'hFFFE;
      check_eq("forced_count", err_count, 16'hFFFE);
      for (int i = 6; i < 12; i++) do_op($urandom_range(0, 3), (i % 2) == 1, 0, 0);
      check_eq("sat_count", err_count, 16'hFFFF);
      check_eq("sat_err_addr", err_addr, 24'h1BC);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
